// File: rtl/toy_fe_ctrl_pkg.sv
// Shared frontend types: redirect payload, redirect priorities and controller FSM states.
package toy_pack;

  localparam int ADDR_WIDTH = 32;

  localparam logic [1:0] FE_PRI_BE   = 2'd3;
  localparam logic [1:0] FE_PRI_TAGE = 2'd2;
  localparam logic [1:0] FE_PRI_BTB  = 2'd1;
  localparam logic [1:0] FE_PRI_L0   = 2'd0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] tgt_pc;
    logic                  taken;
    logic [1:0]            br_type;
  } bpu_pkg;

  typedef enum logic {
    FE_RUN   = 1'b0,
    FE_FLUSH = 1'b1
  } fe_state_e;

  // A controller redirect carries only a target; every other payload field stays zero.
  function automatic bpu_pkg mk_redirect(input logic [ADDR_WIDTH-1:0] pc);
    bpu_pkg p;
    p        = '0;
    p.tgt_pc = pc;
    return p;
  endfunction

endpackage

// File: rtl/toy_fe_credit.sv
// Fetch-queue credit counter: load to full, +1 on pop, -1 on fire, saturating at both ends.
module toy_fe_credit #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = FULL;
    end else if (inc && !dec && count_reg != FULL) begin
      count_next = count_reg + 1'b1;
    end else if (dec && !inc && count_reg != '0) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= FULL;
    end else begin
      count_reg <= count_next;
    end
  end

  // Over/underflow means the fetch protocol was violated upstream; hardware just saturates.
  always_ff @(posedge clk) begin
    if (!rst && !load) begin
      assert (!(inc && !dec && count_reg == FULL));
      assert (!(dec && !inc && count_reg == '0));
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/toy_fe_ctrl.sv
// Frontend controller: arbitrates redirects into one pending slot, issues to the PC generator,
// and drives stall from pending/flush-recovery/credits/ROB availability.
module toy_fe_ctrl
  import toy_pack::*;
#(
  parameter int FQ_DEPTH     = 8,
  parameter int FLUSH_BUBBLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  be_flush_vld,
  input  logic [ADDR_WIDTH-1:0] be_flush_pc,
  input  logic                  tage_ovr_vld,
  input  logic [ADDR_WIDTH-1:0] tage_ovr_pc,
  input  logic                  btb_ovr_vld,
  input  logic [ADDR_WIDTH-1:0] btb_ovr_pc,
  input  logic                  l0btb_pred_vld,
  input  logic [ADDR_WIDTH-1:0] l0btb_pred_pc,
  input  logic                  icache_req_fire,
  input  logic                  fq_pop,
  input  logic                  rob_prealloc_avail,
  output logic                  fe_ctrl_stall,
  output logic                  fe_ctrl_chgflw_vld,
  output bpu_pkg                fe_ctrl_chgflw_pld,
  input  logic                  fe_ctrl_chgflw_rdy,
  output logic                  fe_ctrl_kill_vld,
  output logic [1:0]            fe_ctrl_kill_src
);

  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int BW = $clog2(FLUSH_BUBBLE + 1);

  logic                  win_vld;
  logic [1:0]            win_pri;
  logic [ADDR_WIDTH-1:0] win_pc;

  logic                  pend_vld_reg;
  logic [1:0]            pend_pri_reg;
  logic [ADDR_WIDTH-1:0] pend_pc_reg;

  fe_state_e             state_reg, state_next;
  logic [BW-1:0]         bubble_reg, bubble_next;

  logic                  issue;
  logic                  be_issue;
  logic                  take_win;
  logic [CW-1:0]         credits;

  always_comb begin
    win_vld = 1'b1;
    win_pri = FE_PRI_L0;
    win_pc  = l0btb_pred_pc;
    if (be_flush_vld) begin
      win_pri = FE_PRI_BE;
      win_pc  = be_flush_pc;
    end else if (tage_ovr_vld) begin
      win_pri = FE_PRI_TAGE;
      win_pc  = tage_ovr_pc;
    end else if (btb_ovr_vld) begin
      win_pri = FE_PRI_BTB;
      win_pc  = btb_ovr_pc;
    end else if (!l0btb_pred_vld) begin
      win_vld = 1'b0;
    end
  end

  assign issue    = !rst && pend_vld_reg && fe_ctrl_chgflw_rdy && (state_reg != FE_FLUSH);
  assign be_issue = issue && (pend_pri_reg == FE_PRI_BE);
  // Equal-or-higher priority replaces pending, even while the old entry is issuing.
  assign take_win = win_vld && (!pend_vld_reg || win_pri >= pend_pri_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld_reg <= 1'b0;
      pend_pri_reg <= 2'd0;
      pend_pc_reg  <= '0;
    end else if (take_win) begin
      pend_vld_reg <= 1'b1;
      pend_pri_reg <= win_pri;
      pend_pc_reg  <= win_pc;
    end else if (issue) begin
      pend_vld_reg <= 1'b0;
    end
  end

  always_comb begin
    state_next  = state_reg;
    bubble_next = bubble_reg;
    case (state_reg)
      FE_RUN: begin
        if (be_issue) begin
          state_next  = FE_FLUSH;
          bubble_next = BW'(FLUSH_BUBBLE - 1);
        end
      end
      FE_FLUSH: begin
        if (be_flush_vld) begin
          bubble_next = BW'(FLUSH_BUBBLE - 1);
        end else if (bubble_reg == '0) begin
          state_next = FE_RUN;
        end else begin
          bubble_next = bubble_reg - 1'b1;
        end
      end
      default: state_next = FE_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= FE_RUN;
      bubble_reg <= '0;
    end else begin
      state_reg  <= state_next;
      bubble_reg <= bubble_next;
    end
  end

  toy_fe_credit #(
    .DEPTH (FQ_DEPTH),
    .CW    (CW)
  ) u_credit (
    .clk   (clk),
    .rst   (rst),
    .load  (be_issue),
    .inc   (fq_pop),
    .dec   (icache_req_fire),
    .count (credits)
  );

  assign fe_ctrl_chgflw_vld = issue;
  assign fe_ctrl_chgflw_pld = issue ? mk_redirect(pend_pc_reg) : '0;
  assign fe_ctrl_kill_vld   = issue;
  assign fe_ctrl_kill_src   = issue ? pend_pri_reg : 2'd0;
  assign fe_ctrl_stall      = rst || pend_vld_reg || (state_reg == FE_FLUSH) ||
                              (credits == '0) || !rob_prealloc_avail;

endmodule
